// File: rtl/pc_jump_seq_if.sv
// Jump request handshake between the control decoder (master) and the
// PC jump sequencer (slave).
interface pc_jump_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_cond;
  logic        req_call;

  modport master (
    output req_valid,
    output req_addr,
    output req_cond,
    output req_call,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_cond,
    input  req_call,
    output req_ready
  );
endinterface

// File: rtl/pc_jump_seq.sv
// PC jump sequencer: turns an accepted jump target into the PCHITMP/PC/PCLO
// load strobe sequence on the shared D bus, and captures call return addresses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no strobes, D bus released, ready for a request
// S_HI    | _pchitmp_in low, D = target high byte
// S_LO    | _pc_in low, D = target low byte, PC loads at closing edge
// S_SHORT | _pclo_in low, D = target low byte, PCLO loads at closing edge
module pc_jump_seq #(
  parameter bit SHORT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        _MR,
  pc_jump_seq_if.slave req,
  input  logic [7:0]  PCHI,
  input  logic [7:0]  PCLO,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        _pchitmp_in,
  output logic        _pc_in,
  output logic        _pclo_in,
  output logic        done,
  output logic        taken,
  output logic [15:0] link
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HI    = 2'd1,
    S_LO    = 2'd2,
    S_SHORT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] link_q, link_d;
  logic        done_q, done_d;
  logic        taken_q, taken_d;
  logic        rdy_q;
  logic        accept;
  logic        same_page;

  // rdy_q holds ready off until the first edge after reset release
  assign req.req_ready = rdy_q && (state_q == S_IDLE);
  assign accept        = req.req_valid && req.req_ready;
  // PCLO==FF would carry into PCHI on the accept edge, so the page match is stale
  assign same_page     = SHORT_EN && (req.req_addr[15:8] == PCHI) && (PCLO != 8'hFF);

  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      state_q  <= S_IDLE;
      target_q <= 16'h0000;
      link_q   <= 16'h0000;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      link_q   <= link_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      rdy_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    link_d      = link_q;
    done_d      = 1'b0;
    taken_d     = 1'b0;
    _pchitmp_in = 1'b1;
    _pc_in      = 1'b1;
    _pclo_in    = 1'b1;
    D_out       = 8'h00;
    D_oe        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          target_d = req.req_addr;
          if (!req.req_cond) begin
            done_d = 1'b1;
          end else if (same_page) begin
            state_d = S_SHORT;
          end else begin
            state_d = S_HI;
          end
          if (req.req_cond && req.req_call) begin
            link_d = {PCHI, PCLO} + 16'd1;
          end
        end
      end
      S_HI: begin
        _pchitmp_in = 1'b0;
        D_out       = target_q[15:8];
        D_oe        = 1'b1;
        state_d     = S_LO;
      end
      S_LO: begin
        _pc_in  = 1'b0;
        D_out   = target_q[7:0];
        D_oe    = 1'b1;
        state_d = S_IDLE;
        done_d  = 1'b1;
        taken_d = 1'b1;
      end
      S_SHORT: begin
        _pclo_in = 1'b0;
        D_out    = target_q[7:0];
        D_oe     = 1'b1;
        state_d  = S_IDLE;
        done_d   = 1'b1;
        taken_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign done  = done_q;
  assign taken = taken_q;
  assign link  = link_q;

endmodule

// File: doc/pc_jump_seq.md
# pc_jump_seq

Jump sequencer that drives the program counter's load interface: it accepts a 16-bit jump target over a valid/ready handshake and issues the `_pchitmp_in` / `_pc_in` / `_pclo_in` strobe sequence with the matching byte on the shared D bus. It sits between the control decoder and the PC.
- Long jumps take two cycles: PCHITMP load, then full PC load.
- Same-page jumps take one cycle: PCLO load only.
- Calls capture a 16-bit return address.

## Interface
Parameters:
- `SHORT_EN`, default 1: enables the one-cycle same-page jump path. When 0, every taken jump uses the two-cycle path.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `_MR`  in  1  master reset. Asynchronous, active-low.
- `req_valid`  in  1  jump request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_addr`  in  16  jump target, {hi, lo}.
- `req_cond`  in  1  1 = take the jump; 0 = drop it with no strobes.
- `req_call`  in  1  capture the return address on accept.
- `PCHI`, `PCLO`  in  8 each  current PC, observed.
- `D_out`  out  8  byte driven onto the PC D bus.
- `D_oe`  out  1  D bus drive enable.
- `_pchitmp_in`, `_pc_in`, `_pclo_in`  out  1 each  active-low PC strobes.
- `done`  out  1  one-cycle completion pulse.
- `taken`  out  1  valid with `done`; 1 = PC was loaded.
- `link`  out  16  return address register.

## Operation
- States: IDLE, HI, LO, SHORT. `req_ready` = (state == IDLE) and `_MR` high.
- Accept: posedge with `req_valid & req_ready`. On accept, latch `req_addr` into an internal target register.
- Next-state decision at accept:
  - `req_cond == 0` → stay IDLE; pulse `done=1`, `taken=0` next cycle. No strobes.
  - `SHORT_EN`, `req_addr[15:8] == PCHI`, and `PCLO != 8'hFF` → SHORT.
  - otherwise → HI.
- The `PCLO != FF` exclusion is required. The PC increments on the accept edge, so FF would carry into PCHI and make the page compare stale.
- HI: `_pchitmp_in=0`, `D_out=target[15:8]`, `D_oe=1`. The PC still increments this cycle. Next state is LO.
- LO: `_pc_in=0`, `D_out=target[7:0]`, `D_oe=1`. At the closing posedge the PC loads {PCHITMP, D}. Next state is IDLE.
- SHORT: `_pclo_in=0`, `D_out=target[7:0]`, `D_oe=1`. PCLO loads at the closing posedge. Next state is IDLE.
- Completion: `done=1`, `taken=1` for exactly one cycle after leaving LO or SHORT.
- Call: if `req_call` and `req_cond` at accept, `link <= {PCHI,PCLO} + 1`. The add is mod 2^16, so FFFF → 0000.
  - `link` is unchanged for non-calls and for dropped calls.
- Strobe constraints: at most one strobe is low in any cycle. All strobes are high, and `D_oe=0`, whenever the state is IDLE.
- Outputs are registered: driven from state, never combinationally from `req_*`.

## Timing
- Reset (`_MR` low, asynchronous, any state):
  - state → IDLE, all strobes high.
  - `D_oe=0`, `D_out=0`, `done=0`, `taken=0`.
  - `link=16'h0000`, `req_ready=0`.
  - A sequence interrupted mid-flight is abandoned; no completion pulse is issued.
- Latency, accept edge to PC-loaded edge:
  - long jump: 2 cycles.
  - short jump: 1 cycle.
  - dropped: 0 cycles; `done` appears 1 cycle after accept.
- Throughput: `req_ready` is high in the same cycle `done` pulses, so back-to-back requests are allowed.
  - Max rate: one long jump per 3 cycles (accept cycle + HI + LO), or one short jump per 2 cycles.
- A request held while busy must stay stable until accepted. `req_*` is ignored while `req_ready=0`.
- `_MR` rising: `req_ready` goes high at the first posedge after release, not combinationally.

## Test plan
- Reset: hold `_MR=0` over 2 clocks with `req_valid=1` → strobes all 1, `D_oe=0`, `link=0000`, `req_ready=0`, no accept. Release → `req_ready=1` after the next posedge.
- Long jump: PC=00:02, request `req_addr=FF:AA`, cond=1 → one cycle `_pchitmp_in=0`, D=FF; next cycle `_pc_in=0`, D=AA; PC=FF:AA; `done=taken=1` for one cycle.
- Short jump: PC=12:30, request 12:80 → single cycle `_pclo_in=0`, D=80; PC=12:80.
  - Repeat with PC=12:FF, request 12:80 → must take the HI/LO path; PC=12:80.
- Dropped plus call: cond=0, call=1 → no strobe low at any time, `done=1, taken=0`, link unchanged.
  - Then cond=1, call=1 at PC=FF:FF → `link=0000`.
- Back-to-back: assert two long requests consecutively → second accepted in the `done` cycle; strobes never overlap.
- Reset mid-flight: drop `_MR` during LO → `_pc_in` returns to 1 immediately, no `done`, PC not loaded from the sequencer.
